// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch request/response handshake between the fetch stage and the instruction memory
interface imem_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] rsp_addr;
  modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr);
  modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr);
endinterface

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: in-order instruction fetch responder with credit backpressure and flush.
// Define IMEM_PERF_CNT_EN to add the perf_fetch/perf_stall counters.
module imem_fetch_responder #(
  parameter logic [31:0] BASE = 32'h0000_3000,
  parameter int AW = 12,
  parameter int LATENCY = 1,
  parameter int OUT_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  imem_fetch_if.slave bus,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(OUT_MAX + 1);
  localparam int PW = OUT_MAX > 1 ? $clog2(OUT_MAX) : 1;
  typedef struct packed {
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
  } ent_t;
  logic [31:0]   mem [2**AW];
  ent_t          fifo [OUT_MAX];
  logic [CW-1:0] out_cnt, f_cnt;
  logic [PW-1:0] wp, rp;
  logic [30:0]   rd_off, wr_off;
  logic          rd_ok, wr_ok, acc, pop, push_v;
  ent_t          acc_e, push_e;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(OUT_MAX - 1) ? '0 : p + 1'b1;
  endfunction
  // word offsets carry a borrow bit, so below-BASE and above-range both show as high bits set
  always_comb begin
    rd_off = {1'b0, bus.req_addr[31:2]} - {1'b0, BASE[31:2]};
    wr_off = {1'b0, wr_addr[31:2]} - {1'b0, BASE[31:2]};
    rd_ok  = bus.req_addr[1:0] == 2'b00 && rd_off[30:AW] == '0;
    wr_ok  = wr_en && wr_addr[1:0] == 2'b00 && wr_off[30:AW] == '0;
    acc_e  = '{addr: bus.req_addr, err: !rd_ok, data: rd_ok ? mem[rd_off[AW-1:0]] : '0};
  end
  assign bus.req_ready = reset && !flush && out_cnt < CW'(OUT_MAX);
  assign acc           = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = f_cnt != '0;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign {bus.rsp_addr, bus.rsp_err, bus.rsp_data} = bus.rsp_valid ? fifo[rp] : '0;
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_v = acc;
      assign push_e = acc_e;
    end else begin : g_pipe
      logic [LATENCY-2:0] sv;
      ent_t               se [LATENCY-1];
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          sv <= '0;
          for (int k = 0; k < LATENCY - 1; k++) se[k] <= '0;
        end else begin
          sv[0] <= acc;
          se[0] <= acc_e;
          for (int k = 1; k < LATENCY - 1; k++) begin
            sv[k] <= flush ? 1'b0 : sv[k-1];
            se[k] <= se[k-1];
          end
        end
      assign push_v = sv[LATENCY-2];
      assign push_e = se[LATENCY-2];
    end
  endgenerate
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_off[AW-1:0]] <= wr_data;
  always_ff @(posedge clk)
    if (push_v) fifo[wp] <= push_e;
  // outstanding credits bound FIFO occupancy, so no full check is needed on push
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_cnt <= '0;
      f_cnt   <= '0;
      wp      <= '0;
      rp      <= '0;
    end else if (flush) begin
      out_cnt <= '0;
      f_cnt   <= '0;
      wp      <= '0;
      rp      <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(acc) - CW'(pop);
      f_cnt   <= f_cnt + CW'(push_v) - CW'(pop);
      if (push_v) wp <= inc(wp);
      if (pop) rp <= inc(rp);
    end
`ifdef IMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (pop && !bus.rsp_err) perf_fetch <= perf_fetch + 1'b1;
      if (bus.req_valid && !bus.req_ready) perf_stall <= perf_stall + 1'b1;
    end
`endif
endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Responder end of the instruction-fetch interface: accepts fetch addresses from the fetch stage (PC register) and returns instruction words from an internal word array.
- Configurable in-order read latency; backpressure via credit limit.
- Flush input discards all in-flight fetches on exception redirect or branch kill.
- Separate write port preloads program text.

Parameters:
- BASE, 32'h0000_3000, byte address of word 0
- AW, 12, word-index width; array depth = 2**AW words (byte range BASE .. BASE+4*2**AW-1)
- LATENCY, 1, accept-to-response cycles, legal 1..4
- OUT_MAX, 4, max outstanding fetches (pipeline + output FIFO), legal LATENCY..8

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept a request
- req_addr  in  32  fetch byte address (PC)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  instruction word
- rsp_err  out  1  address fault (misaligned or out of range)
- rsp_addr  out  32  address belonging to rsp_data
- flush  in  1  kill all accepted, undelivered fetches
- wr_en  in  1  preload write strobe
- wr_addr  in  32  preload byte address
- wr_data  in  32  preload word

Behaviour:
- Reset (reset=0, asynchronous): outstanding=0, pipeline stages invalid, FIFO empty. rsp_valid=0, rsp_data=0, rsp_err=0, rsp_addr=0. Array contents are not cleared.
- req_ready = !flush && (outstanding < OUT_MAX). It is 0 while reset is asserted.
- Accept = req_valid && req_ready. The array is read in the accept cycle T, so data reflects writes completed before T.
  - Index = (req_addr - BASE)[AW+1:2].
- Fault: req_addr[1:0] != 0, req_addr < BASE, or req_addr >= BASE + 4*2**AW. The entry carries rsp_err=1 and rsp_data=0 (NOP). Faults still consume a slot and return in order.
- Pipeline: LATENCY-1 register stages, then an OUT_MAX-deep FIFO.
  - An entry accepted at T is visible at the FIFO head in cycle T+LATENCY when the FIFO was empty and no earlier entries are outstanding.
  - Order is strictly preserved.
- Output: rsp_valid/rsp_data/rsp_err/rsp_addr come from the FIFO head.
  - Head is held stable while rsp_valid && !rsp_ready.
  - Head pops on rsp_valid && rsp_ready.
- outstanding: +1 on accept, -1 on pop, unchanged when both occur. It never exceeds OUT_MAX, so the FIFO cannot overflow.
- Full: outstanding==OUT_MAX forces req_ready=0. A same-cycle pop does not re-open req_ready until the next cycle; req_ready is registered-state based, with no combinational path from rsp_ready.
- Flush (synchronous, one cycle): all pipeline stages are invalidated, FIFO emptied, outstanding=0. rsp_valid=0 from the next cycle.
  - A request in the flush cycle is not accepted.
  - A pop in the flush cycle is still a valid delivery.
- Write: the array word at the wr_addr index is updated at the clock edge when wr_en=1 and wr_addr is aligned and in range. Otherwise the write is ignored.
  - Writes proceed regardless of flush.
  - A same-cycle write and accept to the same word returns the OLD word.
- reset asserted mid-operation drops everything immediately. There are no partial responses after release.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- Defined: adds output perf_fetch (32) and perf_stall (32).
  - perf_fetch counts pops with rsp_err=0.
  - perf_stall counts cycles with req_valid && !req_ready.
  - Both are reset to 0 by reset, not by flush, and wrap at 2**32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Preload word 0 = 32'h3c01_1234 via wr_en/wr_addr=32'h3000; LATENCY=1; request 32'h3000 with rsp_ready=1 -> rsp_valid in the next cycle, rsp_data=32'h3c01_1234, rsp_err=0, rsp_addr=32'h3000.
- LATENCY=3; back-to-back requests 32'h3000, 32'h3004, 32'h3008 -> responses appear in cycles T+3, T+4, T+5 in order.
- rsp_ready=0; issue requests until req_ready drops -> exactly OUT_MAX=4 accepted. Raise rsp_ready -> 4 in-order responses, then req_ready returns to 1.
- Request 32'h3002, then 32'h2ffc, then 32'h7000 (AW=12) -> three responses, each with rsp_err=1, rsp_data=0.
- Fill 3 outstanding, assert flush one cycle together with req_valid -> request not accepted, rsp_valid=0 next cycle, outstanding=0. A new request 32'h4180 then returns normally.
- Same-cycle write of 32'hFFFF_FFFF and fetch to 32'h3010 holding 32'h0000_0001 -> response 32'h0000_0001; a repeat fetch returns 32'hFFFF_FFFF.
